// File: rtl/bcd_seq_adder.sv
// Multi-digit packed-BCD adder/subtractor: one digit per clock, LSD first, with a single
// shared 4-bit add/+6 correction stage and valid/ready handshakes on both sides.
module bcd_seq_adder #(
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*N_DIGITS-1:0] a,
   input  logic [4*N_DIGITS-1:0] b,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*N_DIGITS-1:0] sum,
   output logic                  cout,
   output logic                  err
);

   localparam int W     = 4 * N_DIGITS;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         bad = bad | (v[4*i +: 4] > 4'd9);
      end
      return bad;
   endfunction

   function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         r[4*i +: 4] = 4'd9 - v[4*i +: 4];
      end
      return r;
   endfunction

   // Returns {carry, digit}; out-of-range digits go through the same rule unchanged.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                                input logic c);
      logic [4:0] t;
      logic [4:0] tc;
      t  = {1'b0, x} + {1'b0, y} + {4'b0000, c};
      tc = t + 5'd6;
      if (t > 5'd9) begin
         return {1'b1, tc[3:0]};
      end else begin
         return {1'b0, t[3:0]};
      end
   endfunction

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             sub_q, sub_d, carry_q, carry_d, err_q, err_d, cout_q, cout_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [4:0]       digit_s;

   assign digit_s = bcd_digit_add(a_q[{idx_q, 2'b00} +: 4], b_q[{idx_q, 2'b00} +: 4], carry_q);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      err_d    = err_q;
      idx_d    = idx_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? nines_comp(b) : b;
               sub_d   = sub;
               carry_d = sub;
               err_d   = has_bad_digit(a) | has_bad_digit(b);
               idx_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            sum_d[{idx_q, 2'b00} +: 4] = digit_s[3:0];
            carry_d = digit_s[4];
            idx_d   = idx_q + IDX_W'(1);
            // A subtract that produces no final carry means A<B, reported as a borrow.
            if (idx_q == LAST_IDX) begin
               cout_d  = sub_q ? ~digit_s[4] : digit_s[4];
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         carry_q     <= carry_d;
         err_q       <= err_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign err       = err_q;

endmodule
